// File: rtl/react_timer_ctrl_pkg.sv
// react_timer_ctrl_pkg: shared game-state encodings and LFSR constants for the reaction timer
package react_timer_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_CLR_CNT1 = 3'd2,
    ST_START    = 3'd3,
    ST_STORAGE  = 3'd4,
    ST_CLR_CNT2 = 3'd5,
    ST_AVERAGE  = 3'd6,
    ST_COMPARE  = 3'd7
  } game_state_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction
endpackage

// File: rtl/react_timer_ctrl_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler with synchronous clear/hold
//   clk, rstn : clock, async active-low reset
//   clr_i     : forces the prescaler to 0 on the next edge (held while asserted)
//   tick_o    : high in the last cycle of each TICK_DIV-cycle period
module ms_tick_gen
  import react_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  output logic tick_o
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] presc_q, presc_d;
  assign tick_o  = presc_q == PW'(TICK_DIV - 1);
  assign presc_d = (clr_i || tick_o) ? '0 : presc_q + 1'b1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) presc_q <= '0;
    else       presc_q <= presc_d;
endmodule

// File: rtl/react_timer_ctrl.sv
// react_timer_ctrl: timing sequencer producing delay/clear/overflow handshakes for the reaction game
//   clk, rstn     : clock, async active-low reset
//   machine_state : current game state (game_state_e encoding)
//   sig_start     : one-cycle pulse, random pre-start delay expired
//   sig_cleared   : one-cycle pulse, measurement counter cleared
//   sig_overflow  : one-cycle pulse, react_time reached MAX_REACT_MS
//   react_time    : measured reaction time in ms
//   go_led        : high while in START (registered)
//   tick_1ms      : prescaler tick
module react_timer_ctrl
  import react_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV        = 50000,
  parameter int MIN_DELAY_MS    = 1000,
  parameter int DELAY_RAND_BITS = 11,
  parameter int MAX_REACT_MS    = 999
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  machine_state,
  output logic        sig_start,
  output logic        sig_cleared,
  output logic        sig_overflow,
  output logic [15:0] react_time,
  output logic        go_led,
  output logic        tick_1ms
);
  localparam int DW = DELAY_RAND_BITS + 11;
  // Mask form keeps DELAY_RAND_BITS = 0 legal (no zero-width slice).
  localparam logic [15:0] RAND_MASK = 16'((32'd1 << DELAY_RAND_BITS) - 32'd1);
  game_state_e st, prev_q;
  logic [15:0] lfsr_q, lfsr_d, react_q, react_d;
  logic [DW-1:0] delay_q, delay_d, delay_load;
  logic start_q, start_d, clr_q, clr_d, ovf_q, ovf_d, go_q, go_d;
  logic entry, is_clr, tick, react_inc;
  assign st         = game_state_e'(machine_state);
  assign entry      = st != prev_q;
  assign is_clr     = st == ST_CLR_CNT1 || st == ST_CLR_CNT2;
  assign lfsr_d     = lfsr_next(lfsr_q);
  assign delay_load = DW'(MIN_DELAY_MS) + DW'(lfsr_q & RAND_MASK);
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i ((st == ST_WAIT && entry) || is_clr),
    .tick_o(tick)
  );
  // Leaving WAIT discards any pending delay; re-entry always reloads.
  assign delay_d   = st != ST_WAIT ? '0 :
                     entry ? delay_load :
                     (tick && delay_q != '0) ? delay_q - 1'b1 : delay_q;
  assign start_d   = st == ST_WAIT && !entry && tick && delay_q == DW'(1);
  assign clr_d     = is_clr && entry;
  assign react_inc = st == ST_START && tick && react_q < 16'(MAX_REACT_MS);
  assign react_d   = (st == ST_IDLE || clr_d) ? '0 : react_inc ? react_q + 1'b1 : react_q;
  assign ovf_d     = react_inc && react_q == 16'(MAX_REACT_MS - 1);
  assign go_d      = st == ST_START;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      prev_q  <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      delay_q <= '0;
      react_q <= '0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      ovf_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      prev_q  <= st;
      lfsr_q  <= lfsr_d;
      delay_q <= delay_d;
      react_q <= react_d;
      start_q <= start_d;
      clr_q   <= clr_d;
      ovf_q   <= ovf_d;
      go_q    <= go_d;
    end
  assign sig_start    = start_q;
  assign sig_cleared  = clr_q;
  assign sig_overflow = ovf_q;
  assign react_time   = react_q;
  assign go_led       = go_q;
  assign tick_1ms     = tick;
endmodule

// File: tb/tb_react_timer_ctrl.sv
// tb_react_timer_ctrl: directed self-checking bench for react_timer_ctrl
module tb_react_timer_ctrl;
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, CLR1 = 3'd2, START = 3'd3,
                         STOR = 3'd4, CLR2 = 3'd5, AVG = 3'd6, CMP = 3'd7;
  logic clk = 1'b0, rstn = 1'b0;
  logic [2:0] ms = IDLE, ms2 = IDLE;
  logic s_start, s_clr, s_ovf, go, tk;
  logic s_start2, s_clr2, s_ovf2, go2, tk2;
  logic [15:0] rt, rt2, m_lfsr;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  react_timer_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(3), .DELAY_RAND_BITS(0), .MAX_REACT_MS(5)) u_dut (
    .clk(clk), .rstn(rstn), .machine_state(ms), .sig_start(s_start), .sig_cleared(s_clr),
    .sig_overflow(s_ovf), .react_time(rt), .go_led(go), .tick_1ms(tk));
  react_timer_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(3), .DELAY_RAND_BITS(2), .MAX_REACT_MS(5)) u_dut2 (
    .clk(clk), .rstn(rstn), .machine_state(ms2), .sig_start(s_start2), .sig_cleared(s_clr2),
    .sig_overflow(s_ovf2), .react_time(rt2), .go_led(go2), .tick_1ms(tk2));
  always @(posedge clk or negedge rstn)
    if (!rstn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input int n, input logic [15:0] rt_exp, input string tag);
    for (int i = 0; i < n; i++) begin
      nxt();
      chk({tag, "_pulses"}, {s_start, s_clr, s_ovf}, 0);
      chk({tag, "_rt"}, rt, rt_exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pulses"}, {s_start, s_clr, s_ovf}, 0);
    chk({tag, "_rt"}, rt, 0);
    chk({tag, "_go"}, go, 0);
    chk({tag, "_tick"}, tk, 0);
  endtask
  initial begin
    int r, exp_cyc;
    repeat (2) nxt();
    check_reset_outputs("por");
    rstn = 1'b1;
    quiet(100, 0, "idle");
    nxt();
    ms = WAIT;
    for (int k = 1; k <= 33; k++) begin
      nxt();
      chk("wait_start", s_start, k == 13);
      chk("wait_tick", tk, k % 4 == 0);
    end
    nxt();
    ms = CLR1;
    nxt();
    chk("clr1_pulse", s_clr, 1);
    chk("clr1_rt", rt, 0);
    ms = START;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      chk("cnt_rt", rt, k / 4);
      chk("cnt_go", go, 1);
      chk("cnt_pulses", {s_start, s_clr, s_ovf}, 0);
    end
    nxt();
    chk("cnt_rt_s9", rt, 2);
    ms = STOR;
    quiet(50, 2, "storage");
    nxt();
    ms = CLR2;
    nxt();
    chk("clr2_pulse", s_clr, 1);
    chk("clr2_rt", rt, 0);
    ms = START;
    for (int k = 1; k <= 16; k++) begin
      nxt();
      chk("cnt4_rt", rt, k / 4);
    end
    nxt();
    chk("pre_clr_rt", rt, 4);
    ms = CLR1;
    nxt();
    chk("clr_rt", rt, 0);
    chk("clr_pulse", s_clr, 1);
    for (int k = 0; k < 10; k++) begin
      nxt();
      chk("clr_hold_pulse", s_clr, 0);
      chk("clr_hold_rt", rt, 0);
    end
    ms = START;
    for (int k = 1; k <= 40; k++) begin
      nxt();
      chk("ovf_rt", rt, (k / 4 > 5) ? 5 : k / 4);
      chk("ovf_pulse", s_ovf, k == 20);
      chk("ovf_go", go, 1);
    end
    ms = AVG;
    quiet(10, 5, "average");
    ms = CMP;
    quiet(10, 5, "compare");
    ms = IDLE;
    quiet(3, 0, "to_idle");
    ms = WAIT;
    quiet(6, 0, "abort_wait");
    ms = IDLE;
    quiet(20, 0, "abort_idle");
    ms = WAIT;
    for (int k = 1; k <= 20; k++) begin
      nxt();
      chk("rewait_start", s_start, k == 13);
    end
    ms = IDLE;
    ms2 = WAIT;
    r = int'(m_lfsr[1:0]);
    exp_cyc = (3 + r) * 4 + 1;
    for (int k = 1; k <= 40; k++) begin
      nxt();
      chk("rand_start", s_start2, k == exp_cyc);
    end
    ms2 = IDLE;
    nxt();
    ms = CLR1;
    nxt();
    ms = START;
    repeat (10) nxt();
    chk("pre_rst_rt", rt, 2);
    chk("pre_rst_go", go, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    ms = IDLE;
    nxt();
    nxt();
    rstn = 1'b1;
    quiet(100, 0, "post_rst");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
